// File: rtl/seq_checker_0_1_2_3_10_13.sv
// Receive-side checker for the cyclic 4-bit sequence 0,1,2,3,10,13.
// Build option: define SEQ_CHECKER_STICKY_ERR_EN to make o_err sticky until reset.
module seq_checker_0_1_2_3_10_13 #(
  parameter int LOCK_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [3:0]       i_din,
  input  logic             i_valid,
  output logic             o_locked,
  output logic             o_err,
  output logic [3:0]       o_expected,
  output logic [CNT_W-1:0] o_err_count
);

  typedef enum logic [1:0] {
    S_HUNT   = 2'd0,
    S_TRACK  = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  localparam logic [3:0]       LOCK_TGT = 4'(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_idx;
  logic [2:0]       w_idx_nxt;
  logic [2:0]       w_idx_inc;
  logic [3:0]       r_periods;
  logic [3:0]       w_periods_nxt;
  logic [3:0]       w_periods_inc;
  logic             r_locked;
  logic             r_err;
  logic [CNT_W-1:0] r_err_count;
  logic [3:0]       w_seq_val;
  logic             w_match;
  logic             w_last;
  logic             w_violation;

  // Index 0..5 selects 0,1,2,3,10,13; codes 6 and 7 never occur.
  function automatic logic [3:0] seqValue(input logic [2:0] idx);
    logic [3:0] v;
    case (idx)
      3'd0:    v = 4'd0;
      3'd1:    v = 4'd1;
      3'd2:    v = 4'd2;
      3'd3:    v = 4'd3;
      3'd4:    v = 4'd10;
      default: v = 4'd13;
    endcase
    return v;
  endfunction

  assign w_seq_val     = seqValue(r_idx);
  assign w_match       = (i_din == w_seq_val);
  assign w_last        = (r_idx == 3'd5);
  assign w_idx_inc     = w_last ? 3'd0 : r_idx + 3'd1;
  assign w_periods_inc = r_periods + 4'd1;

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_periods_nxt = r_periods;
    w_violation   = 1'b0;
    if (i_valid) begin
      case (r_state)
        S_HUNT: begin
          if (i_din == 4'd0) begin
            w_state_nxt   = S_TRACK;
            w_idx_nxt     = 3'd1;
            w_periods_nxt = 4'd0;
          end
        end
        S_TRACK: begin
          if (w_match) begin
            w_idx_nxt = w_idx_inc;
            if (w_last) begin
              w_periods_nxt = w_periods_inc;
              if (w_periods_inc == LOCK_TGT) begin
                w_state_nxt = S_LOCKED;
              end
            end
          end else begin
            // A stray 0 is treated as the start of a fresh period.
            w_periods_nxt = 4'd0;
            if (i_din == 4'd0) begin
              w_idx_nxt = 3'd1;
            end else begin
              w_state_nxt = S_HUNT;
              w_idx_nxt   = 3'd0;
            end
          end
        end
        S_LOCKED: begin
          if (w_match) begin
            w_idx_nxt = w_idx_inc;
          end else begin
            w_violation = 1'b1;
            if (i_din == 4'd0) begin
              w_state_nxt   = S_TRACK;
              w_idx_nxt     = 3'd1;
              w_periods_nxt = 4'd0;
            end else begin
              w_state_nxt = S_HUNT;
              w_idx_nxt   = 3'd0;
            end
          end
        end
        default: begin
          w_state_nxt   = S_HUNT;
          w_idx_nxt     = 3'd0;
          w_periods_nxt = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_HUNT;
      r_idx       <= 3'd0;
      r_periods   <= 4'd0;
      r_locked    <= 1'b0;
      r_err       <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_periods <= w_periods_nxt;
      r_locked  <= (w_state_nxt == S_LOCKED);
`ifdef SEQ_CHECKER_STICKY_ERR_EN
      r_err     <= r_err | w_violation;
`else
      r_err     <= w_violation;
`endif
      if (w_violation && (r_err_count != CNT_MAX)) begin
        r_err_count <= r_err_count + 1'b1;
      end
    end
  end

  assign o_locked    = r_locked;
  assign o_err       = r_err;
  assign o_err_count = r_err_count;
  assign o_expected  = (r_state == S_HUNT) ? 4'd0 : w_seq_val;

endmodule
